// File: rtl/dds_pkg.sv
// Shared types, reset defaults and the sine table generator for the DDS
// waveform generator.
package dds_pkg;

    // Waveform selector; encodings match the cfg_mode port.
    typedef enum logic [1:0] {
        MODE_SINE = 2'd0,
        MODE_SQU  = 2'd1,
        MODE_TRI  = 2'd2,
        MODE_SAW  = 2'd3
    } mode_e;

    // Waveform selected out of reset.
    localparam mode_e RST_MODE = MODE_SINE;

    // One full-wave offset-binary sine sample for table index i.
    // Index 0 is midscale and the peaks sit at +/-(2^(data_w-1)-1) around
    // midscale, so the wave is symmetric.  The half-wave shape uses the
    // Bhaskara rational approximation: sin ~ 16v / (5h^2 - 4v) with
    // v = u*(h-u).  It is exact at 0, the quarter points and the half point,
    // and it needs only integer arithmetic at elaboration time.
    function automatic int sine_sample(input int i, input int addr_w, input int data_w);
        longint li;
        longint h;
        longint u;
        longint v;
        longint den;
        longint mag;
        longint peak;
        longint mid;
        li   = longint'(i);
        h    = longint'(1) << (addr_w - 1);
        u    = li % h;
        v    = u * (h - u);
        den  = 5 * h * h - 4 * v;
        mid  = longint'(1) << (data_w - 1);
        peak = mid - 1;
        mag  = (peak * 16 * v + den / 2) / den;
        if (li >= h) begin
            return int'(mid - mag);
        end
        return int'(mid + mag);
    endfunction

endpackage

// File: rtl/dds_wave_gen_sine_lut.sv
// Full-wave sine ROM: 2^ADDR_W entries of DATA_W-bit offset-binary samples,
// registered read (one cycle).  The table contents are computed at
// elaboration, so no external memory image is required.
module sine_lut
    import dds_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = DATA_W'(sine_sample(i, ADDR_W, DATA_W));
    end

    // Registered ROM read; aligns the sine sample with the other S2 results.
    always_ff @(posedge clk) begin
        q <= rom[addr];
    end

endmodule

// File: rtl/dds_wave_gen.sv
// DDS waveform generator: phase accumulator, shadowed configuration applied
// only at safe points (phase clear, idle/stopped, or accumulator carry),
// and a three-stage waveform/amplitude pipeline driving the DAC bus.
//
// Config handshake: a word transfers on any cycle where cfg_valid and
// cfg_ready are both high; cfg_ready is high exactly when the shadow
// register is empty, and drops the cycle after a transfer until the shadow
// is applied to the active configuration.
//
// The config record is declared here rather than in dds_pkg because its
// field widths follow this module's parameters.
module dds_wave_gen
    import dds_pkg::*;
#(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int AMP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_clr,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [ADDR_W-1:0]  cfg_duty,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic               wrap
);

    typedef struct packed {
        mode_e              mode;
        logic [PHASE_W-1:0] ftw;
        logic [PHASE_W-1:0] poff;
        logic [AMP_W-1:0]   amp;
        logic [ADDR_W-1:0]  duty;
    } cfg_t;

    // Product width wide enough for raw * (amp + 1) without overflow.
    localparam int PROD_W = DATA_W + AMP_W + 1;

    // Reset defaults: sine, stopped, no offset, full scale, 50% duty.
    localparam logic [ADDR_W-1:0] RST_DUTY = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam cfg_t CFG_RST = '{
        mode: RST_MODE,
        ftw:  {PHASE_W{1'b0}},
        poff: {PHASE_W{1'b0}},
        amp:  {AMP_W{1'b1}},
        duty: RST_DUTY
    };

    // ---------------------------------------------------------------------
    // Configuration: shadow register and active set
    // ---------------------------------------------------------------------
    cfg_t act_cfg;
    cfg_t shd_cfg;
    cfg_t in_cfg;
    logic pending;

    logic [PHASE_W:0]   acc_sum;
    logic [PHASE_W-1:0] acc;
    logic               wrap_q;
    logic               carry_now;
    logic               ftw_zero;
    logic               accept;
    logic               apply;

    assign in_cfg = '{
        mode: mode_e'(cfg_mode),
        ftw:  cfg_ftw,
        poff: cfg_poff,
        amp:  cfg_amp,
        duty: cfg_duty
    };

    assign cfg_ready = !pending;
    assign accept    = cfg_valid && !pending;

    // Carry only counts when the accumulator really steps this cycle.
    assign acc_sum   = {1'b0, acc} + {1'b0, act_cfg.ftw};
    assign carry_now = en && !phase_clr && acc_sum[PHASE_W];
    assign ftw_zero  = (act_cfg.ftw == {PHASE_W{1'b0}});

    // A shadow word becomes active on a phase clear, while the accumulator
    // is not moving, or on the carry-out edge (phase-continuous switch).
    assign apply = pending && (phase_clr || !en || ftw_zero || carry_now);

    // Capture offered config into the shadow; move shadow to active at an apply event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_cfg <= CFG_RST;
            shd_cfg <= CFG_RST;
            pending <= 1'b0;
        end else if (accept) begin
            shd_cfg <= in_cfg;
            pending <= 1'b1;
        end else if (apply) begin
            act_cfg <= shd_cfg;
            pending <= 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // Phase accumulator
    // ---------------------------------------------------------------------

    // Step the accumulator by the active tuning word; phase_clr restarts it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc    <= '0;
            wrap_q <= 1'b0;
        end else if (phase_clr) begin
            acc    <= '0;
            wrap_q <= 1'b0;
        end else if (en) begin
            acc    <= acc_sum[PHASE_W-1:0];
            wrap_q <= acc_sum[PHASE_W];
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign wrap = wrap_q;

    // ---------------------------------------------------------------------
    // S1: phase offset and table index; per-sample settings travel along
    // ---------------------------------------------------------------------
    logic [PHASE_W-1:0] phase_sum;
    logic [ADDR_W-1:0]  s1_idx;
    mode_e              s1_mode;
    logic [AMP_W-1:0]   s1_amp;
    logic [ADDR_W-1:0]  s1_duty;
    logic               s1_valid;

    assign phase_sum = acc + act_cfg.poff;

    // Register the index taken from the top of the offset phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_idx   <= '0;
            s1_mode  <= MODE_SINE;
            s1_amp   <= '0;
            s1_duty  <= '0;
            s1_valid <= 1'b0;
        end else begin
            s1_idx   <= ADDR_W'(phase_sum >> (PHASE_W - ADDR_W));
            s1_mode  <= act_cfg.mode;
            s1_amp   <= act_cfg.amp;
            s1_duty  <= act_cfg.duty;
            s1_valid <= en;
        end
    end

    // ---------------------------------------------------------------------
    // S2: raw waveform value (sine comes from the registered ROM)
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] lut_q;
    logic [ADDR_W-1:0] tri_full;
    logic [DATA_W-1:0] raw_calc;
    logic [DATA_W-1:0] s2_raw;
    mode_e             s2_mode;
    logic [AMP_W-1:0]  s2_amp;
    logic              s2_valid;

    sine_lut #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_sine_lut (
        .clk  (clk),
        .addr (s1_idx),
        .q    (lut_q)
    );

    // Square, triangle and sawtooth shapes from the S1 index.
    always_comb begin
        raw_calc = '0;
        // Doubling the low bits folds the index into a rising/falling ramp;
        // inverting {x,0} gives {~x,1}, so the falling half ends at 1.
        tri_full = {s1_idx[ADDR_W-1] ? ~s1_idx[ADDR_W-2:0] : s1_idx[ADDR_W-2:0],
                    s1_idx[ADDR_W-1]};
        case (s1_mode)
            MODE_SQU: raw_calc = (s1_idx < s1_duty) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
            MODE_TRI: raw_calc = DATA_W'(tri_full >> (ADDR_W - DATA_W));
            MODE_SAW: raw_calc = DATA_W'(s1_idx >> (ADDR_W - DATA_W));
            default:  raw_calc = '0;
        endcase
    end

    // Register the computed shape alongside the ROM read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_raw   <= '0;
            s2_mode  <= MODE_SINE;
            s2_amp   <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_raw   <= raw_calc;
            s2_mode  <= s1_mode;
            s2_amp   <= s1_amp;
            s2_valid <= s1_valid;
        end
    end

    // ---------------------------------------------------------------------
    // S3: amplitude scaling and output register
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] raw_sel;
    logic [PROD_W-1:0] prod;

    // Scaling by (amp + 1) makes an all-ones amplitude an exact pass-through.
    assign raw_sel = (s2_mode == MODE_SINE) ? lut_q : s2_raw;
    assign prod    = PROD_W'(raw_sel) * (PROD_W'(s2_amp) + PROD_W'(1));

    // Drive the DAC bus; idle samples are forced to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout       <= s2_valid ? DATA_W'(prod >> AMP_W) : {DATA_W{1'b0}};
            dout_valid <= s2_valid;
        end
    end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Self-checking bench for dds_wave_gen (PHASE_W=16, ADDR_W=8, DATA_W=8,
// AMP_W=8): a table of steady-state sample vectors plus hand-written
// sequences for reset, wrap timing, mid-period config and phase clear.
module tb_dds_wave_gen;

    localparam int PHASE_W = 16;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int AMP_W   = 8;

    // Clock / reset block
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               en = 1'b0;
    logic               phase_clr = 1'b0;
    logic               cfg_valid = 1'b0;
    logic               cfg_ready;
    logic [1:0]         cfg_mode = '0;
    logic [PHASE_W-1:0] cfg_ftw = '0;
    logic [PHASE_W-1:0] cfg_poff = '0;
    logic [AMP_W-1:0]   cfg_amp = '0;
    logic [ADDR_W-1:0]  cfg_duty = '0;
    logic [DATA_W-1:0]  dout;
    logic               dout_valid;
    logic               wrap;

    dds_wave_gen #(
        .PHASE_W (PHASE_W),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .AMP_W   (AMP_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .phase_clr  (phase_clr),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_mode   (cfg_mode),
        .cfg_ftw    (cfg_ftw),
        .cfg_poff   (cfg_poff),
        .cfg_amp    (cfg_amp),
        .cfg_duty   (cfg_duty),
        .dout       (dout),
        .dout_valid (dout_valid),
        .wrap       (wrap)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] ftw;
        logic [15:0] poff;
        logic [7:0]  amp;
        logic [7:0]  duty;
        int          k;     // sample number after the first valid sample
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[$];
    logic [DATA_W-1:0] exp_q[$];

    // Watchdog: a stuck run still reports before stopping.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        phase_clr = 1'b0;
        cfg_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic offer_cfg(input logic [1:0] m, input logic [15:0] f, input logic [15:0] p,
                             input logic [7:0] a, input logic [7:0] d);
        cfg_mode  = m;
        cfg_ftw   = f;
        cfg_poff  = p;
        cfg_amp   = a;
        cfg_duty  = d;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Offer a config while stopped, let it apply, then start running.
    task automatic load_and_run(input logic [1:0] m, input logic [15:0] f, input logic [15:0] p,
                                input logic [7:0] a, input logic [7:0] d);
        offer_cfg(m, f, p, a, d);
        tick();
        en = 1'b1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!dout_valid && n < 10) begin
            tick();
            n++;
        end
        check("first_valid", int'(dout_valid), 1);
    endtask

    task automatic add_vec(input logic [1:0] m, input logic [15:0] f, input logic [15:0] p,
                           input logic [7:0] a, input logic [7:0] d, input int k,
                           input logic [7:0] e);
        vec_t v;
        v.mode = m; v.ftw = f; v.poff = p; v.amp = a; v.duty = d; v.k = k; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        // -------------------------------------------------------------
        // Vector table: sample k counted from the first valid sample,
        // acc starts at 0, so index = (k*ftw + poff) >> 8.
        // -------------------------------------------------------------
        // sawtooth
        add_vec(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80,   0, 8'h00);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80,   1, 8'h01);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80, 255, 8'hFF);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80, 256, 8'h00);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'h7F, 8'h80, 100, 8'h32);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'h7F, 8'h80, 254, 8'h7F);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'h7F, 8'h80, 255, 8'h7F);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'h7F, 8'h80,   3, 8'h01);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'h80, 8'h80, 200, 8'h64);
        add_vec(2'd3, 16'h0100, 16'h0000, 8'h00, 8'h80, 200, 8'h00);
        add_vec(2'd3, 16'h0100, 16'h8000, 8'hFF, 8'h80,   0, 8'h80);
        add_vec(2'd3, 16'h0300, 16'h0000, 8'hFF, 8'h80,   2, 8'h06);
        add_vec(2'd3, 16'h0080, 16'h0000, 8'hFF, 8'h80,   5, 8'h02);
        // square, duty 64
        add_vec(2'd1, 16'h0100, 16'h0000, 8'hFF, 8'h40,   0, 8'hFF);
        add_vec(2'd1, 16'h0100, 16'h0000, 8'hFF, 8'h40,  63, 8'hFF);
        add_vec(2'd1, 16'h0100, 16'h0000, 8'hFF, 8'h40,  64, 8'h00);
        add_vec(2'd1, 16'h0100, 16'h0000, 8'hFF, 8'h40, 255, 8'h00);
        add_vec(2'd1, 16'h0100, 16'h0000, 8'hFF, 8'h40, 256, 8'hFF);
        add_vec(2'd1, 16'h0100, 16'h0000, 8'h7F, 8'h40,  10, 8'h7F);
        // square, duty 0 is constant low
        add_vec(2'd1, 16'h0100, 16'h0000, 8'hFF, 8'h00,   0, 8'h00);
        add_vec(2'd1, 16'h0100, 16'h0000, 8'hFF, 8'h00, 100, 8'h00);
        // triangle
        add_vec(2'd2, 16'h0100, 16'h0000, 8'hFF, 8'h80,   0, 8'h00);
        add_vec(2'd2, 16'h0100, 16'h0000, 8'hFF, 8'h80,   1, 8'h02);
        add_vec(2'd2, 16'h0100, 16'h0000, 8'hFF, 8'h80, 127, 8'hFE);
        add_vec(2'd2, 16'h0100, 16'h0000, 8'hFF, 8'h80, 128, 8'hFF);
        add_vec(2'd2, 16'h0100, 16'h0000, 8'hFF, 8'h80, 129, 8'hFD);
        add_vec(2'd2, 16'h0100, 16'h0000, 8'hFF, 8'h80, 255, 8'h01);
        // sine: midscale at 0 and 180 degrees, peaks at 90 / 270
        add_vec(2'd0, 16'h0100, 16'h0000, 8'hFF, 8'h80,   0, 8'h80);
        add_vec(2'd0, 16'h0100, 16'h0000, 8'hFF, 8'h80,  64, 8'hFF);
        add_vec(2'd0, 16'h0100, 16'h0000, 8'hFF, 8'h80, 128, 8'h80);
        add_vec(2'd0, 16'h0100, 16'h0000, 8'hFF, 8'h80, 192, 8'h01);

        // -------------------------------------------------------------
        // Reset state
        // -------------------------------------------------------------
        do_reset();
        check("rst_dout", int'(dout), 0);
        check("rst_dout_valid", int'(dout_valid), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_wrap", int'(wrap), 0);

        // Reset mid-run drops the pipeline and a pending config
        load_and_run(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80);
        repeat (20) tick();
        offer_cfg(2'd3, 16'h0100, 16'h4000, 8'hFF, 8'h80);
        check("midrst_pending", int'(cfg_ready), 0);
        rst_n = 1'b0;
        tick();
        check("midrst_dout", int'(dout), 0);
        check("midrst_dout_valid", int'(dout_valid), 0);
        check("midrst_cfg_ready", int'(cfg_ready), 1);
        check("midrst_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        wait_valid();
        check("midrst_default_s0", int'(dout), 8'h80);
        repeat (5) tick();
        check("midrst_default_s5", int'(dout), 8'h80);

        // -------------------------------------------------------------
        // Table-driven vectors
        // -------------------------------------------------------------
        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            load_and_run(vecs[i].mode, vecs[i].ftw, vecs[i].poff, vecs[i].amp, vecs[i].duty);
            wait_valid();
            repeat (vecs[i].k) tick();
            check($sformatf("vec%0d_dout", i), int'(dout), int'(vecs[i].exp));
            check($sformatf("vec%0d_valid", i), int'(dout_valid), 1);
        end

        // -------------------------------------------------------------
        // Wrap pulse timing and en falling
        // -------------------------------------------------------------
        begin
            int n;
            int m;
            do_reset();
            load_and_run(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80);
            n = 0;
            while (n < 300) begin
                tick();
                n++;
                if (wrap) break;
            end
            check("first_wrap_cycle", n, 256);
            check("dout_at_wrap", int'(dout), 8'hFD);
            tick();
            check("wrap_width", int'(wrap), 0);
            m = 1;
            while (m < 400) begin
                tick();
                m++;
                if (wrap) break;
            end
            check("wrap_period", m, 256);
            en = 1'b0;
            tick();
            check("en_fall_valid1", int'(dout_valid), 1);
            tick();
            check("en_fall_valid2", int'(dout_valid), 1);
            tick();
            check("en_fall_valid3", int'(dout_valid), 0);
            check("en_fall_dout", int'(dout), 0);
            check("en_fall_wrap", int'(wrap), 0);
        end

        // -------------------------------------------------------------
        // Config accepted mid-period waits for the wrap
        // -------------------------------------------------------------
        begin
            int n;
            int early_ready;
            do_reset();
            load_and_run(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80);
            n = 0;
            while (!(dout_valid && dout == 8'd37) && n < 100) begin
                tick();
                n++;
            end
            check("sync_idx40", int'(dout), 37);
            // acc index is 40 now; dout trails it by three samples
            for (int c = 3; c <= 218; c++) exp_q.push_back(DATA_W'(37 + c));
            exp_q.push_back(8'h80);
            offer_cfg(2'd0, 16'h0200, 16'h0000, 8'hFF, 8'h80);     // c = 1
            check("pending_after_accept", int'(cfg_ready), 0);
            offer_cfg(2'd3, 16'h0100, 16'h4000, 8'h40, 8'h80);     // c = 2, refused
            check("second_cfg_refused", int'(cfg_ready), 0);
            early_ready = 0;
            for (int c = 3; c <= 251; c++) begin
                tick();
                if (c < 216 && cfg_ready !== 1'b0) early_ready++;
                if (c == 216) begin
                    check("ready_at_wrap", int'(cfg_ready), 1);
                    check("wrap_at_apply", int'(wrap), 1);
                end
                if (exp_q.size() > 0) begin
                    check($sformatf("midcfg_c%0d", c), int'(dout), int'(exp_q.pop_front()));
                end
                if (c == 251) check("new_sine_peak", int'(dout), 8'hFF);
            end
            check("ready_low_until_wrap", early_ready, 0);
        end

        // -------------------------------------------------------------
        // phase_clr restarts the accumulator and applies pending config
        // -------------------------------------------------------------
        do_reset();
        load_and_run(2'd3, 16'h0100, 16'h0000, 8'hFF, 8'h80);
        repeat (50) tick();
        offer_cfg(2'd0, 16'h0100, 16'h8000, 8'hFF, 8'h80);
        check("clr_pending", int'(cfg_ready), 0);
        phase_clr = 1'b1;
        tick();
        phase_clr = 1'b0;
        check("clr_ready", int'(cfg_ready), 1);
        check("clr_wrap", int'(wrap), 0);
        repeat (3) tick();
        check("clr_first_sample", int'(dout), 8'h80);
        check("clr_first_valid", int'(dout_valid), 1);
        repeat (64) tick();
        check("clr_sample64", int'(dout), 8'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
